// File: rtl/dio_seq_pkg.sv
// dio_seq_pkg
// Shared definitions for the DIO pin sequencer.
//   PINS      : number of DIO pins handled by the sequencer (8)
//   CFG_W     : width of one entry's pin configuration {value, state}
//   seq_state_t : sequencer FSM states IDLE / ARMED / RUN / DONE
//   pin_cfg_t   : per-entry pin levels and directions (state 1 = input)
//   pinMux    : per-pin select between sequencer bits and manual bits
package dio_seq_pkg;

   localparam int PINS  = 8;
   localparam int CFG_W = 2 * PINS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [PINS-1:0] value;
      logic [PINS-1:0] state;
   } pin_cfg_t;

   // Pins whose mask bit is set take the sequencer bit, the rest the manual bit.
   function automatic logic [PINS-1:0] pinMux(input logic [PINS-1:0] seqBits,
                                              input logic [PINS-1:0] manBits,
                                              input logic [PINS-1:0] mask);
      return (seqBits & mask) | (manBits & ~mask);
   endfunction

endpackage

// File: rtl/dio_sync.sv
// dio_sync
// Multi-bit flop-chain synchroniser for the asynchronous DIO pin readback.
// Each bit is synchronised independently; the readback is a level snapshot,
// so no bus coherency is implied.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous reset, active-high (clears every stage)
//   i_data  in   W   raw asynchronous inputs
//   o_data  out  W   synchronised outputs, SYNC_STG cycles of latency
module dio_sync #(
   parameter int SYNC_STG = 2,
   parameter int W        = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data
);

   logic [W-1:0] r_stage [SYNC_STG];

   // Shift the raw inputs through SYNC_STG flops; stage 0 is the metastable one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STG; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_data;
         for (int i = 1; i < SYNC_STG; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_data = r_stage[SYNC_STG-1];

endmodule

// File: rtl/dio_sequencer.sv
// dio_sequencer
// Drives the value/state inputs of the 8-pin DIO tristate buffer block from a
// small pattern table, muxed per pin against static software levels, and
// synchronises the DIO pin readback into the clk domain.
// Optional feature macro: DIO_SEQ_CAPTURE_EN adds cap_data/cap_valid, which
// snapshot the synchronised readback each time a table entry is loaded.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   man_value/man_state  in 8  static levels / directions (1=input) for manual pins
//   seq_mask             in 8  1 = pin owned by the sequencer
//   tbl_we/addr/wdata    in    table write port, wdata = {value, state, hold}
//   num_entries          in    active entry count (0 = disabled, clamps to DEPTH)
//   loop_en, trig_mode   in    wrap after last entry / arm and wait for trig rise
//   start, stop, trig    in    control pulses and external trigger
//   dio_in               in 8  raw asynchronous pin readback
//   dio_value/dio_state  out 8 registered drive to the DIO buffer
//   dio_in_sync          out 8 synchronised readback
//   busy, cur_entry, done out  status
module dio_sequencer
   import dio_seq_pkg::*;
#(
   parameter int  DEPTH    = 16,
   parameter int  HOLD_W   = 16,
   parameter int  SYNC_STG = 2,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           man_value,
   input  logic [7:0]           man_state,
   input  logic [7:0]           seq_mask,
   input  logic                 tbl_we,
   input  logic [AW-1:0]        tbl_addr,
   input  logic [16+HOLD_W-1:0] tbl_wdata,
   input  logic [AW:0]          num_entries,
   input  logic                 loop_en,
   input  logic                 trig_mode,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 trig,
   input  logic [7:0]           dio_in,
   output logic [7:0]           dio_value,
   output logic [7:0]           dio_state,
   output logic [7:0]           dio_in_sync,
   output logic                 busy,
   output logic [AW-1:0]        cur_entry,
   output logic                 done
`ifdef DIO_SEQ_CAPTURE_EN
   ,
   output logic [7:0]           cap_data,
   output logic                 cap_valid
`endif
);

   localparam int             ENT_W   = CFG_W + HOLD_W;
   localparam logic [AW:0]    DEPTH_N = DEPTH[AW:0];

   logic [ENT_W-1:0]  r_tbl [DEPTH];
   seq_state_t        r_state, w_next_state;
   logic [AW-1:0]     r_idx, w_next_idx;
   logic [HOLD_W-1:0] r_hold;
   pin_cfg_t          r_cfg, w_cfg;
   logic              r_trig_prev;
   logic              w_trig_rise, w_last, w_load;
   logic [AW:0]       w_eff_num;
   logic [ENT_W-1:0]  w_entry;
   logic [7:0]        r_dio_value, r_dio_state;
   logic [7:0]        w_dio_in_sync;

   // Pattern table: plain storage, writable at any time. A running entry keeps
   // its latched copy, so a write only shows up the next time it is loaded.
   always_ff @(posedge clk) begin
      if (tbl_we) r_tbl[tbl_addr] <= tbl_wdata;
   end

   // num_entries is used live so software can shorten a running sequence;
   // "last" is a >= test so lowering it below the current entry ends right here.
   assign w_eff_num   = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
   assign w_last      = ({1'b0, r_idx} + {{AW{1'b0}}, 1'b1}) >= w_eff_num;
   assign w_trig_rise = trig & ~r_trig_prev;
   assign w_entry     = r_tbl[w_next_idx];
   assign w_cfg       = w_load ? pin_cfg_t'(w_entry[ENT_W-1 -: CFG_W]) : r_cfg;

   // Next-state logic. w_load marks the edge at which a table entry is latched;
   // the output registers see the freshly read entry on that same edge, which
   // is what gives entry 0 its single cycle of latency after start/trig.
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      w_load       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && (num_entries != '0)) begin
               if (trig_mode) begin
                  w_next_state = ARMED;
               end else begin
                  w_next_state = RUN;
                  w_next_idx   = '0;
                  w_load       = 1'b1;
               end
            end
         end
         ARMED: begin
            if (w_trig_rise) begin
               w_next_state = RUN;
               w_next_idx   = '0;
               w_load       = 1'b1;
            end
         end
         RUN: begin
            if (r_hold == '0) begin
               if (!w_last) begin
                  w_next_idx = r_idx + 1'b1;
                  w_load     = 1'b1;
               end else if (loop_en) begin
                  w_next_idx = '0;
                  w_load     = 1'b1;
               end else begin
                  w_next_state = DONE;
               end
            end
         end
         DONE: w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
      if (stop) begin
         w_next_state = IDLE;
         w_next_idx   = r_idx;
         w_load       = 1'b0;
      end
   end

   // State, entry latch, hold countdown and registered pin outputs. A loaded
   // entry with hold h stays on the pins for h+1 cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_hold      <= '0;
         r_cfg       <= '0;
         r_trig_prev <= 1'b0;
         r_dio_value <= 8'h00;
         r_dio_state <= 8'hFF;
      end else begin
         r_state     <= w_next_state;
         r_trig_prev <= trig;
         if (w_load) begin
            r_idx  <= w_next_idx;
            r_hold <= w_entry[HOLD_W-1:0];
            r_cfg  <= w_cfg;
         end else if (r_hold != '0) begin
            r_hold <= r_hold - HOLD_W'(1);
         end
         if (w_next_state == RUN) begin
            r_dio_value <= pinMux(w_cfg.value, man_value, seq_mask);
            r_dio_state <= pinMux(w_cfg.state, man_state, seq_mask);
         end else begin
            r_dio_value <= man_value;
            r_dio_state <= man_state;
         end
      end
   end

   dio_sync #(
      .SYNC_STG (SYNC_STG),
      .W        (8)
   ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .i_data (dio_in),
      .o_data (w_dio_in_sync)
   );

`ifdef DIO_SEQ_CAPTURE_EN
   logic [7:0] r_cap_data;
   logic       r_cap_valid;

   // Snapshot the synchronised readback at every entry load, including wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cap_data  <= '0;
         r_cap_valid <= 1'b0;
      end else begin
         r_cap_valid <= w_load;
         if (w_load) r_cap_data <= w_dio_in_sync;
      end
   end

   assign cap_data  = r_cap_data;
   assign cap_valid = r_cap_valid;
`endif

   assign dio_value   = r_dio_value;
   assign dio_state   = r_dio_state;
   assign dio_in_sync = w_dio_in_sync;
   assign busy        = (r_state == ARMED) || (r_state == RUN);
   assign done        = (r_state == DONE);
   assign cur_entry   = r_idx;

endmodule
